// File: rtl/iigs_pkg.sv
// Shared shadowing constants, drain FSM encoding and queue entry type
// for the IIgs fast-to-slow RAM shadow write path.
package iigs_pkg;

    localparam int SH_TXT1 = 0;
    localparam int SH_HGR1 = 1;
    localparam int SH_HGR2 = 2;
    localparam int SH_SHR  = 3;
    localparam int SH_AUX  = 4;
    localparam int SH_TXT2 = 5;

    localparam logic [15:0] TXT1_LO = 16'h0400;
    localparam logic [15:0] TXT1_HI = 16'h07FF;
    localparam logic [15:0] TXT2_LO = 16'h0800;
    localparam logic [15:0] TXT2_HI = 16'h0BFF;
    localparam logic [15:0] HGR1_LO = 16'h2000;
    localparam logic [15:0] HGR1_HI = 16'h3FFF;
    localparam logic [15:0] HGR2_LO = 16'h4000;
    localparam logic [15:0] HGR2_HI = 16'h5FFF;
    localparam logic [15:0] SHR_LO  = 16'h2000;
    localparam logic [15:0] SHR_HI  = 16'h9FFF;

    localparam logic [7:0] BANK_FAST0 = 8'h00;
    localparam logic [7:0] BANK_FAST1 = 8'h01;
    localparam logic [7:0] BANK_SLOW0 = 8'hE0;
    localparam logic [7:0] BANK_SLOW1 = 8'hE1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_WRITE = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic        bank0;
        logic [15:0] addr;
        logic [7:0]  data;
    } shadow_entry_t;

    function automatic logic in_range(
        input logic [15:0] a,
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        return (a >= lo) && (a <= hi);
    endfunction

    // Any uninhibited region covering the address makes it a shadow hit;
    // bit 4 only masks the hi-res regions of bank 01.
    function automatic logic shadowed(
        input logic        bank0,
        input logic [15:0] a,
        input logic [7:0]  sh
    );
        logic aux_inh;
        aux_inh = bank0 & sh[SH_AUX];
        return (in_range(a, TXT1_LO, TXT1_HI) & ~sh[SH_TXT1])
             | (in_range(a, TXT2_LO, TXT2_HI) & ~sh[SH_TXT2])
             | (in_range(a, HGR1_LO, HGR1_HI) & ~sh[SH_HGR1] & ~aux_inh)
             | (in_range(a, HGR2_LO, HGR2_HI) & ~sh[SH_HGR2] & ~aux_inh)
             | (bank0 & in_range(a, SHR_LO, SHR_HI) & ~sh[SH_SHR]);
    endfunction

endpackage

// File: rtl/shadow_fifo.sv
// Synchronous FIFO of pending shadow writes.
// Pointers wrap modulo DEPTH; level is the registered occupancy.
module shadow_fifo
    import iigs_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  shadow_entry_t wdata,
    output shadow_entry_t rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    shadow_entry_t mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/shadow_ctrl.sv
// Queues CPU writes to shadowed bank 00/01 regions and replays them
// to slow RAM at the 1MHz rate, stalling the CPU when ordering demands.
module shadow_ctrl
    import iigs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   slow_ce,
    input  logic                   cpu_ce,
    input  logic [7:0]             bank,
    input  logic [15:0]            addr,
    input  logic [7:0]             dout,
    input  logic                   we,
    input  logic [7:0]             shadow_reg,
    output logic                   stall,
    output logic [16:0]            sr_addr,
    output logic [7:0]             sr_din,
    output logic                   sr_wr,
    output logic [$clog2(DEPTH):0] q_level
);

    drain_state_t  state;
    shadow_entry_t wentry;
    shadow_entry_t head;
    logic          fast_bank;
    logic          slow_bank;
    logic          hit;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign fast_bank = (bank == BANK_FAST0) || (bank == BANK_FAST1);
    assign slow_bank = (bank == BANK_SLOW0) || (bank == BANK_SLOW1);
    assign hit = cpu_ce & we & fast_bank
               & shadowed(bank[0], addr, shadow_reg);

    assign push = hit & ~full;
    assign pop  = (state == ST_PEND) & slow_ce & ~empty;

    // Direct slow-bank accesses wait until every queued write has landed.
    assign stall = (hit & full) | (cpu_ce & slow_bank & ~empty);

    assign wentry = '{bank0: bank[0], addr: addr, data: dout};

    shadow_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wdata   (wentry),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (q_level)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= ST_IDLE;
            sr_wr   <= 1'b0;
            sr_addr <= '0;
            sr_din  <= '0;
        end else begin
            sr_wr <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (push) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (slow_ce) begin
                        sr_wr   <= 1'b1;
                        sr_addr <= {head.bank0, head.addr};
                        sr_din  <= head.data;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state <= ((q_level != '0) || push) ? ST_PEND : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/shadow_ctrl.md
SHADOW_CTRL -- requirements
Module: shadow_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, shadow write queue depth in entries (power of 2, >=2).
REQ-002 SHALL have port clk_sys  input  1  system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port slow_ce  input  1  one-clk_sys-cycle strobe at the 1MHz slow-bus rate.
REQ-005 SHALL have port cpu_ce  input  1  CPU bus cycle valid, one clk_sys cycle per access.
REQ-006 SHALL have port bank  input  8  CPU bank.
REQ-007 SHALL have port addr  input  16  CPU address.
REQ-008 SHALL have port dout  input  8  CPU write data.
REQ-009 SHALL have port we  input  1  CPU write.
REQ-010 SHALL have port shadow_reg  input  8  $C035 shadow register; bit=1 inhibits that region.
REQ-011 SHALL have port stall  output  1  CPU hold request; combinational.
REQ-012 SHALL have port sr_addr  output  17  slowram address {bank[0],addr}; registered.
REQ-013 SHALL have port sr_din  output  8  slowram write data; registered.
REQ-014 SHALL have port sr_wr  output  1  slowram write strobe; registered, one cycle.
REQ-015 SHALL have port q_level  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL define shadow hit = cpu_ce & we & bank in {00,01} & addr in an uninhibited region.
REQ-017 SHALL use these regions: $0400-07FF bit0; $0800-0BFF bit5; $2000-3FFF bit1; $4000-5FFF bit2; bank 01 only, $2000-9FFF bit3.
REQ-018 SHALL treat bit4 = 1 as inhibiting the bit1/bit2 regions in bank 01 only.
REQ-019 SHALL treat bits 6 and 7 as don't-care.
REQ-020 SHALL push {bank[0],addr,dout} in the cycle of a shadow hit when not full.
REQ-021 SHALL assert stall = shadow hit & full, with no push; the CPU holds the access until a slot is free.
REQ-022 SHALL evaluate full from registered occupancy; a pop in the same cycle does not clear stall in that cycle.
REQ-023 SHALL assert stall = cpu_ce & bank in {E0,E1} & queue not empty, so direct slow-bank accesses are ordered after pending shadow writes.
REQ-024 SHALL run a drain FSM with states IDLE (empty), PEND (non-empty, waiting for slow_ce) and WRITE (sr_wr high).
REQ-025 SHALL move IDLE->PEND on push; PEND->WRITE on slow_ce, popping the head into sr_addr/sr_din.
REQ-026 SHALL spend exactly one cycle in WRITE, then go to PEND if entries remain, else IDLE.
REQ-027 SHALL allow a push in the same cycle as a pop, leaving occupancy unchanged.
REQ-028 SHALL have minimum latency from push to sr_wr = 2 cycles (slow_ce in the cycle after push, sr_wr in the following cycle).
REQ-029 SHALL drain at most one entry per slow_ce, in FIFO order; writes to the same address are all kept, with no coalescing.
REQ-030 SHALL wrap read/write pointers modulo DEPTH; occupancy never exceeds DEPTH or underflows.
REQ-031 SHALL ignore reads in banks 00/01 and writes to non-shadowed addresses (no push, no stall).

Reset
REQ-032 SHALL, on reset, set the FSM to IDLE, pointers and q_level to 0, and sr_wr, sr_addr and sr_din to 0.
REQ-033 SHALL, on reset mid-operation, discard all pending entries and drop stall, with no sr_wr in the cycle after reset.

Structure
REQ-034 SHALL place shadow bit indices, region bounds and the FSM state encoding in the shared package iigs_pkg.
REQ-035 SHALL implement the queue as one sub-module, shadow_fifo (synchronous FIFO with push/pop/full/empty/level).

Verification
REQ-036 SHALL cover: shadow_reg=00, write 00:0400=5A, slow_ce 1 cycle later -> sr_wr with sr_addr=00400, sr_din=5A, exactly 2 cycles after push.
REQ-037 SHALL cover: shadow_reg=01, write 00:0400 -> no push, no sr_wr; write 01:2000 with bit3=0 -> sr_addr=12000.
REQ-038 SHALL cover: DEPTH=4, 5 back-to-back writes 00:2000-2004, no slow_ce -> stall on the 5th; slow_ce -> 5th accepted next cycle; drain order 2000..2004.
REQ-039 SHALL cover: queue holds 2, CPU reads E0:0400 -> stall until q_level=0, then released.
REQ-040 SHALL cover: queue holds 3, reset asserted 1 cycle -> q_level=0, stall=0, no sr_wr after reset, even with slow_ce pulses.
